// File: rtl/clock_set_ctrl.sv
// Set-mode controller for the digital clock: walks the six time/date fields on button pulses,
// then issues an OW_LEN-cycle overwrite strobe carrying the edited values.
module clock_set_ctrl #(
  parameter int unsigned OW_LEN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [16:0] time_cur,
  input  logic [20:0] date_cur,
  output logic [16:0] time_set,
  output logic [20:0] date_set,
  output logic        time_ow,
  output logic        date_ow,
  output logic        editing,
  output logic [2:0]  field_sel
);

  // Edit states share their encoding with the field_sel code of the field they edit.
  typedef enum logic [2:0] {
    StHour   = 3'd0,
    StMin    = 3'd1,
    StSec    = 3'd2,
    StDay    = 3'd3,
    StMon    = 3'd4,
    StYear   = 3'd5,
    StCommit = 3'd6,
    StIdle   = 3'd7
  } state_e;

  state_e      state_q;
  logic [3:0]  ow_cnt_q;

  logic [4:0]  hour, day, dmax, day_clamped;
  logic [5:0]  min, sec;
  logic [3:0]  mon;
  logic [11:0] year;
  logic        leap;
  logic [11:0] sel_val, sel_lo, sel_hi, stepped;
  logic [16:0] time_step;
  logic [20:0] date_step;

  // Out-of-range values snap to the near end of the range in the stepping direction.
  function automatic logic [11:0] step_val(input logic [11:0] v, input logic [11:0] lo,
                                           input logic [11:0] hi, input logic up);
    if (up) begin
      return (v < lo || v >= hi) ? lo : v + 12'd1;
    end
    return (v <= lo || v > hi) ? hi : v - 12'd1;
  endfunction

  always_comb begin
    hour = time_set[16:12];
    min  = time_set[11:6];
    sec  = time_set[5:0];
    day  = date_set[20:16];
    mon  = date_set[15:12];
    year = date_set[11:0];

    leap = (year[1:0] == 2'd0) &&
           (((year % 12'd100) != 12'd0) || ((year % 12'd400) == 12'd0));

    case (mon)
      4'd2:                     dmax = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  dmax = 5'd30;
      default:                  dmax = 5'd31;
    endcase

    day_clamped = (day > dmax) ? dmax : day;

    sel_val = '0;
    sel_lo  = '0;
    sel_hi  = '0;
    case (state_q)
      StHour: begin sel_val = {7'd0, hour}; sel_lo = 12'd0; sel_hi = 12'd23;       end
      StMin:  begin sel_val = {6'd0, min};  sel_lo = 12'd0; sel_hi = 12'd59;       end
      StSec:  begin sel_val = {6'd0, sec};  sel_lo = 12'd0; sel_hi = 12'd59;       end
      StDay:  begin sel_val = {7'd0, day};  sel_lo = 12'd1; sel_hi = {7'd0, dmax}; end
      StMon:  begin sel_val = {8'd0, mon};  sel_lo = 12'd1; sel_hi = 12'd12;       end
      StYear: begin sel_val = year;         sel_lo = 12'd0; sel_hi = 12'd4095;     end
      default: ;
    endcase

    // inc outranks dec when both arrive together
    stepped = step_val(sel_val, sel_lo, sel_hi, btn_inc);

    time_step = time_set;
    date_step = date_set;
    case (state_q)
      StHour:  time_step[16:12] = stepped[4:0];
      StMin:   time_step[11:6]  = stepped[5:0];
      StSec:   time_step[5:0]   = stepped[5:0];
      StDay:   date_step[20:16] = stepped[4:0];
      StMon:   date_step[15:12] = stepped[3:0];
      StYear:  date_step[11:0]  = stepped;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ow_cnt_q  <= '0;
      time_set  <= '0;
      date_set  <= {5'd1, 4'd1, 12'd0};
      time_ow   <= 1'b0;
      date_ow   <= 1'b0;
      editing   <= 1'b0;
      field_sel <= 3'd7;
    end else begin
      case (state_q)
        StIdle: begin
          if (btn_mode) begin
            time_set  <= time_cur;
            date_set  <= date_cur;
            state_q   <= StHour;
            editing   <= 1'b1;
            field_sel <= 3'd0;
          end
        end
        StHour, StMin, StSec, StDay, StMon, StYear: begin
          if (btn_mode) begin
            state_q   <= StIdle;
            editing   <= 1'b0;
            field_sel <= 3'd7;
          end else if (btn_next) begin
            if (state_q == StYear) begin
              date_set[20:16] <= day_clamped;
              state_q         <= StCommit;
              ow_cnt_q        <= 4'(OW_LEN - 1);
              time_ow         <= 1'b1;
              date_ow         <= 1'b1;
              editing         <= 1'b0;
              field_sel       <= 3'd7;
            end else begin
              state_q   <= state_e'(state_q + 3'd1);
              field_sel <= state_q + 3'd1;
            end
          end else if (btn_inc || btn_dec) begin
            time_set <= time_step;
            date_set <= date_step;
          end
        end
        StCommit: begin
          // ow_cnt_q holds the strobe cycles still to come after this one
          if (ow_cnt_q == 4'd0) begin
            time_ow <= 1'b0;
            date_ow <= 1'b0;
            state_q <= StIdle;
          end else begin
            ow_cnt_q <= ow_cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: two instances (OW_LEN 2 and 4) share stimulus and are compared
// every cycle against a field-level reference model, plus directed boundary checks.
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [16:0] time_cur = '0;
  logic [20:0] date_cur = '0;

  logic [16:0] ts [2];
  logic [20:0] ds [2];
  logic        tow [2], dow [2], ed [2];
  logic [2:0]  fs [2];

  int vectors = 0;
  int miscompares = 0;

  // Model state per instance: mst 0..5 editing that field, 6 commit, 7 idle.
  int mst [2], cnt [2], ow [2];
  int hh [2], mm [2], ss [2], dd [2], mo [2], yy [2];
  int owl [2] = '{2, 4};

  always #5 clk = ~clk;

  clock_set_ctrl #(.OW_LEN(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .time_cur(time_cur), .date_cur(date_cur), .time_set(ts[0]),
    .date_set(ds[0]), .time_ow(tow[0]), .date_ow(dow[0]), .editing(ed[0]), .field_sel(fs[0])
  );

  clock_set_ctrl #(.OW_LEN(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .time_cur(time_cur), .date_cur(date_cur), .time_set(ts[1]),
    .date_set(ds[1]), .time_ow(tow[1]), .date_ow(dow[1]), .editing(ed[1]), .field_sel(fs[1])
  );

  function automatic int dmax_f(int m, int y);
    bit lp;
    lp = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    if (m == 2) return lp ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int step_f(int v, int lo, int hi, bit up);
    if (v < lo || v > hi) return up ? lo : hi;
    if (up) return (v == hi) ? lo : v + 1;
    return (v == lo) ? hi : v - 1;
  endfunction

  task automatic model_reset(int k);
    mst[k] = 7; cnt[k] = 0; ow[k] = 0;
    hh[k] = 0; mm[k] = 0; ss[k] = 0; dd[k] = 1; mo[k] = 1; yy[k] = 0;
  endtask

  task automatic model_update(int k);
    bit up;
    up = btn_inc;
    if (!rst_n) begin
      model_reset(k);
    end else if (mst[k] == 7) begin
      if (btn_mode) begin
        hh[k] = int'(time_cur) / 4096; mm[k] = (int'(time_cur) / 64) % 64;
        ss[k] = int'(time_cur) % 64;
        dd[k] = int'(date_cur) / 65536; mo[k] = (int'(date_cur) / 4096) % 16;
        yy[k] = int'(date_cur) % 4096;
        mst[k] = 0;
      end
    end else if (mst[k] == 6) begin
      cnt[k] = cnt[k] - 1;
      if (cnt[k] == 0) begin ow[k] = 0; mst[k] = 7; end
    end else if (btn_mode) begin
      mst[k] = 7;
    end else if (btn_next) begin
      if (mst[k] == 5) begin
        if (dd[k] > dmax_f(mo[k], yy[k])) dd[k] = dmax_f(mo[k], yy[k]);
        mst[k] = 6; ow[k] = 1; cnt[k] = owl[k];
      end else begin
        mst[k] = mst[k] + 1;
      end
    end else if (btn_inc || btn_dec) begin
      case (mst[k])
        0: hh[k] = step_f(hh[k], 0, 23, up);
        1: mm[k] = step_f(mm[k], 0, 59, up);
        2: ss[k] = step_f(ss[k], 0, 59, up);
        3: dd[k] = step_f(dd[k], 1, dmax_f(mo[k], yy[k]), up);
        4: mo[k] = step_f(mo[k], 1, 12, up);
        default: yy[k] = step_f(yy[k], 0, 4095, up);
      endcase
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("time_set%0d", k), 32'(ts[k]), 32'(hh[k] * 4096 + mm[k] * 64 + ss[k]));
      check($sformatf("date_set%0d", k), 32'(ds[k]), 32'(dd[k] * 65536 + mo[k] * 4096 + yy[k]));
      check($sformatf("time_ow%0d", k), 32'(tow[k]), 32'(ow[k]));
      check($sformatf("date_ow%0d", k), 32'(dow[k]), 32'(ow[k]));
      check($sformatf("editing%0d", k), 32'(ed[k]), 32'(mst[k] < 6));
      check($sformatf("field_sel%0d", k), 32'(fs[k]), 32'((mst[k] < 6) ? mst[k] : 7));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_update(k);
    check_all();
  endtask

  task automatic press(bit m, bit n, bit i, bit d);
    btn_mode = m; btn_next = n; btn_inc = i; btn_dec = d;
    tick();
    btn_mode = 0; btn_next = 0; btn_inc = 0; btn_dec = 0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic set_cur(int h, int m, int s, int d, int mon, int y);
    time_cur = {5'(h), 6'(m), 6'(s)};
    date_cur = {5'(d), 4'(mon), 12'(y)};
  endtask

  int strobes0, strobes1;

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    rst_n = 0;
    idle(2);
    rst_n = 1;
    idle(1);

    // Idle ignores next/inc/dec.
    repeat (20) begin
      btn_next = 1'($urandom_range(0, 1));
      btn_inc  = 1'($urandom_range(0, 1));
      btn_dec  = 1'($urandom_range(0, 1));
      tick();
    end
    btn_next = 0; btn_inc = 0; btn_dec = 0;
    check("idle_time", 32'(ts[0]), 32'd0);
    check("idle_date", 32'(ds[0]), 32'({5'd1, 4'd1, 12'd0}));
    check("idle_fsel", 32'(fs[0]), 32'd7);

    // Main edit sequence.
    set_cur(23, 48, 0, 15, 1, 2020);
    press(1, 0, 0, 0);
    repeat (2) press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    repeat (49) press(0, 0, 0, 1);
    repeat (4) press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    check("main_time", 32'(ts[0]), 32'({5'd1, 6'd59, 6'd0}));
    check("main_date", 32'(ds[0]), 32'({5'd15, 4'd1, 12'd2020}));
    strobes0 = int'(tow[0]); strobes1 = int'(tow[1]);
    repeat (7) begin
      tick();
      strobes0 += int'(tow[0]); strobes1 += int'(tow[1]);
    end
    check("strobe_len2", 32'(strobes0), 32'd2);
    check("strobe_len4", 32'(strobes1), 32'd4);

    // Day wrap in a leap February.
    set_cur(12, 0, 0, 29, 2, 2024);
    press(1, 0, 0, 0);
    repeat (3) press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    check("leap_inc", 32'(ds[0][20:16]), 32'd1);
    press(0, 0, 0, 1);
    check("leap_dec", 32'(ds[0][20:16]), 32'd29);
    press(1, 0, 0, 0);

    set_cur(12, 0, 0, 1, 2, 2100);
    press(1, 0, 0, 0);
    repeat (3) press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    check("y2100_dec", 32'(ds[0][20:16]), 32'd28);
    press(1, 0, 0, 0);

    set_cur(12, 0, 0, 1, 2, 2000);
    press(1, 0, 0, 0);
    repeat (3) press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    check("y2000_dec", 32'(ds[0][20:16]), 32'd29);
    press(1, 0, 0, 0);

    // Clamp of day 31 into April on commit.
    set_cur(12, 0, 0, 31, 1, 2020);
    press(1, 0, 0, 0);
    repeat (4) press(0, 1, 0, 0);
    repeat (3) press(0, 0, 1, 0);
    repeat (2) press(0, 1, 0, 0);
    check("clamp_day", 32'(ds[0][20:16]), 32'd30);
    check("clamp_ow", 32'(tow[0]), 32'd1);
    idle(6);

    // Cancel and priority.
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    check("cancel_ed", 32'(ed[0]), 32'd0);
    idle(3);
    press(1, 0, 0, 0);
    repeat (2) press(0, 1, 0, 0);
    press(1, 1, 0, 0);
    check("mode_next", 32'(ed[0]), 32'd0);
    set_cur(12, 0, 0, 1, 1, 2020);
    press(1, 0, 0, 0);
    press(0, 0, 1, 1);
    check("inc_dec", 32'(ts[0][16:12]), 32'd13);
    press(1, 0, 0, 0);

    // Reset in the first commit cycle.
    press(1, 0, 0, 0);
    repeat (5) press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    check("commit_ow4", 32'(tow[1]), 32'd1);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("rst_ow4", 32'(tow[1]), 32'd0);
    check("rst_date4", 32'(ds[1]), 32'({5'd1, 4'd1, 12'd0}));
    idle(2);

    // Randomized traffic.
    repeat (600) begin
      if ($urandom_range(0, 9) == 0)
        set_cur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
                $urandom_range(0, 31), $urandom_range(1, 12), $urandom_range(0, 4095));
      btn_mode = ($urandom_range(0, 99) < 6);
      btn_next = ($urandom_range(0, 99) < 15);
      btn_inc  = ($urandom_range(0, 99) < 25);
      btn_dec  = ($urandom_range(0, 99) < 25);
      rst_n    = ($urandom_range(0, 99) >= 2);
      tick();
      btn_mode = 0; btn_next = 0; btn_inc = 0; btn_dec = 0;
      rst_n = 1;
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
